// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the PC sequencer slice.
//   seq_state_t : sequencer FSM states (FETCH, EXEC, HALT)
//   OP_*        : opcodes decoded from instruction bits [15:12]
//   opcode()    : extracts the opcode field from a 16-bit instruction
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [3:0] opcode(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Fetch and execute handshakes between the sequencer and its neighbours.
//   imem_req   : fetch request            (sequencer -> instruction memory)
//   imem_ready : fetch data valid          (instruction memory -> sequencer)
//   imem_rdata : fetched instruction       (instruction memory -> sequencer)
//   ex_start   : one-cycle execute start   (sequencer -> execute unit)
//   ex_done    : execute complete          (execute unit -> sequencer)
//   zero_flag  : ALU zero, valid w/ ex_done (execute unit -> sequencer)
// master = sequencer side, slave = memory/execute side.
// -----------------------------------------------------------------------------
interface pc_sequencer_if;

    logic        imem_req;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        ex_start;
    logic        ex_done;
    logic        zero_flag;

    modport master (
        output imem_req,
        input  imem_ready,
        input  imem_rdata,
        output ex_start,
        input  ex_done,
        input  zero_flag
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        output imem_rdata,
        input  ex_start,
        output ex_done,
        output zero_flag
    );

endinterface

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC select. The PC only moves on the cycle an
// instruction completes (EXEC with ex_done); every other cycle it holds.
//   state     : sequencer state
//   ir        : instruction being executed
//   ex_done   : execute complete this cycle
//   zero_flag : ALU zero result, qualifies BEQ/BNE
//   pc_count  : current PC
//   pc_branch : pc_count + 2, branch target
//   pc_next   : selected next PC
// -----------------------------------------------------------------------------
module pc_next_sel
    import cpu_pkg::*;
(
    input  seq_state_t  state,
    input  logic [15:0] ir,
    input  logic        ex_done,
    input  logic        zero_flag,
    input  logic [15:0] pc_count,
    input  logic [15:0] pc_branch,
    output logic [15:0] pc_next
);

    logic [15:0] pc_inc;

    // Natural 16-bit overflow gives the 0xFFFF -> 0x0000 wrap.
    assign pc_inc = pc_count + 16'd1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_next = pc_count;
        if (state == EXEC && ex_done) begin
            case (opcode(ir))
                OP_BEQ:  pc_next = zero_flag  ? pc_branch : pc_inc;
                OP_BNE:  pc_next = !zero_flag ? pc_branch : pc_inc;
                OP_JMP:  pc_next = {pc_count[15:12], ir[11:0]};
                default: pc_next = pc_inc;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch/execute sequencer driving an external PC register. Fetches an
// instruction, pulses ex_start, waits for ex_done, then steps the PC.
// A fetch that stalls FETCH_TIMEOUT consecutive cycles raises a sticky fault
// and parks the sequencer in HALT, as does a fetched HALT opcode.
//   clk, reset : clock and synchronous active-high reset
//   pc_count   : current PC from the PC register
//   pc_branch  : pc_count + 2 from the PC register
//   pc_next    : next PC, loaded by the PC register every edge
//   bus        : fetch/execute handshakes (master side)
//   ir         : instruction register
//   retired    : retired-instruction count (wraps)
//   halted     : sequencer is in HALT
//   fetch_err  : sticky fetch-timeout fault
// -----------------------------------------------------------------------------
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   pc_count,
    input  logic [15:0]   pc_branch,
    output logic [15:0]   pc_next,
    pc_sequencer_if.master bus,
    output logic [15:0]   ir,
    output logic [15:0]   retired,
    output logic          halted,
    output logic          fetch_err
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    // Count value seen during the last permissible stalled cycle.
    localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

    seq_state_t    state;
    seq_state_t    state_next;
    logic          capture;
    logic          timeout;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   sel_pc;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the
        // clocked block and is not in the sensitivity list.
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            FETCH: begin
                // A ready on the last permissible cycle still captures.
                if (bus.imem_ready) begin
                    capture    = 1'b1;
                    state_next = (opcode(bus.imem_rdata) == OP_HALT) ? HALT : EXEC;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = HALT;
                end
            end
            EXEC: begin
                if (bus.ex_done) begin
                    state_next = FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // -------------------------------------------------- registered outputs
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            ir           <= 16'h0000;
            bus.ex_start <= 1'b0;
            retired      <= 16'h0000;
            halted       <= 1'b0;
            fetch_err    <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            if (capture) begin
                ir <= bus.imem_rdata;
            end
            bus.ex_start <= capture && (state_next == EXEC);
            if (state == EXEC && bus.ex_done) begin
                retired <= retired + 16'd1;
            end
            halted <= (state_next == HALT);
            if (timeout) begin
                fetch_err <= 1'b1;
            end
            // Only consecutive stalled cycles inside one FETCH accumulate.
            if (state == FETCH && !bus.imem_ready && state_next == FETCH) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------- combinational outputs
    pc_next_sel u_pc_next_sel (
        .state     (state),
        .ir        (ir),
        .ex_done   (bus.ex_done),
        .zero_flag (bus.zero_flag),
        .pc_count  (pc_count),
        .pc_branch (pc_branch),
        .pc_next   (sel_pc)
    );

    // Reset forces PC zero combinationally so the PC register loads 0 on
    // the same edge the sequencer resets.
    assign pc_next      = reset ? 16'h0000 : sel_pc;
    assign bus.imem_req = (state == FETCH) && !reset;

endmodule
